rf_writeback_collector: RTL and testbench

Gathers a polynomial result that a functional unit emits one residue per cycle into a full `vec_t` buffer. When the buffer is complete, it issues a single-cycle writeback to one register-file dest port: dest valid, dest register index and dest coefficient vector. It sits between a streaming FU output and the register file's `dest0`/`dest1` write port, one instance per port, and adds the sequencing, counting and backpressure the register file does not provide.

---
 rtl/rf_writeback_collector.sv | 130 +++++++++++++
 tb/tb_rf_writeback_collector.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_collector.sv
// rtl/rf_writeback_collector.sv - gathers one residue per cycle into a full vector and issues a single-cycle RF writeback
//
// Purpose: sits between a streaming functional-unit output and one register-file
// dest port. Counts accepted residues into a buffer and, once all NELEM are in,
// raises dest_valid for exactly one cycle with the latched register index.
//
// Ports:
//   clk, reset                - clock, synchronous active-high reset
//   start, start_dest_index   - begin a collection, target register (latched on accept)
//   start_ready               - start accepted when start && start_ready
//   abort                     - drop the collection in progress
//   in_valid, in_data         - residue stream, flat index order
//   in_ready                  - residue accepted when in_valid && in_ready
//   dest_valid                - one-cycle writeback strobe
//   dest_register_index       - latched target register
//   dest_coefficient          - assembled polynomial (the buffer register itself)
//   busy                      - collecting or flushing
//   elem_count                - residues accepted in the current collection
module rf_writeback_collector #(
    parameter int COEFF_W = 16,
    parameter int NCOEFF  = 4,
    parameter int NPRIMES = 2,
    parameter int NREG    = 16,
    localparam int NELEM  = NCOEFF * NPRIMES,
    localparam int CNT_W  = $clog2(NELEM + 1),
    localparam int IDX_W  = $clog2(NREG)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [IDX_W-1:0]                 start_dest_index,
    output logic                             start_ready,
    input  logic                             abort,
    input  logic                             in_valid,
    input  logic [COEFF_W-1:0]               in_data,
    output logic                             in_ready,
    output logic                             dest_valid,
    output logic [IDX_W-1:0]                 dest_register_index,
    output logic [NELEM-1:0][COEFF_W-1:0]    dest_coefficient,
    output logic                             busy,
    output logic [CNT_W-1:0]                 elem_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_FLUSH
    } state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [NELEM-1:0][COEFF_W-1:0]   buf_q;
    logic                            buf_we;

    // All handshake outputs depend on state only, so there is no
    // combinational path from start/in_valid back to the ready signals.
    assign start_ready         = (state_q == S_IDLE) || (state_q == S_FLUSH);
    assign in_ready            = (state_q == S_COLLECT);
    assign dest_valid          = (state_q == S_FLUSH);
    assign busy                = (state_q == S_COLLECT) || (state_q == S_FLUSH);
    assign elem_count          = count_q;
    assign dest_register_index = idx_q;
    assign dest_coefficient    = buf_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        buf_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_COLLECT;
                    idx_d   = start_dest_index;
                    count_d = '0;
                end
            end
            S_COLLECT: begin
                // Abort takes priority even over the final element, so a
                // coincident abort never produces a writeback.
                if (abort) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (in_valid) begin
                    buf_we  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(NELEM - 1)) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // Accepting start here gives back-to-back collections.
                if (start) begin
                    state_d = S_COLLECT;
                    idx_d   = start_dest_index;
                    count_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            // Compare-per-slot write avoids indexing the buffer with a
            // counter wider than the slot address.
            for (int i = 0; i < NELEM; i++) begin
                if (buf_we && (count_q == CNT_W'(i))) begin
                    buf_q[i] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_writeback_collector.sv
// tb/tb_rf_writeback_collector.sv - self-checking bench for rf_writeback_collector
module tb_rf_writeback_collector;

    localparam int COEFF_W = 16;
    localparam int NELEM   = 8;
    localparam int CNT_W   = 4;
    localparam int IDX_W   = 4;

    logic                           clk = 1'b0;
    logic                           reset;
    logic                           start;
    logic [IDX_W-1:0]               start_dest_index;
    logic                           start_ready;
    logic                           abort;
    logic                           in_valid;
    logic [COEFF_W-1:0]             in_data;
    logic                           in_ready;
    logic                           dest_valid;
    logic [IDX_W-1:0]               dest_register_index;
    logic [NELEM-1:0][COEFF_W-1:0]  dest_coefficient;
    logic                           busy;
    logic [CNT_W-1:0]               elem_count;

    rf_writeback_collector #(
        .COEFF_W(COEFF_W), .NCOEFF(4), .NPRIMES(2), .NREG(16)
    ) dut (
        .clk(clk), .reset(reset),
        .start(start), .start_dest_index(start_dest_index), .start_ready(start_ready),
        .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .dest_valid(dest_valid), .dest_register_index(dest_register_index),
        .dest_coefficient(dest_coefficient),
        .busy(busy), .elem_count(elem_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [COEFF_W-1:0] exp_vec [NELEM];
    int pulse_cyc;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; start = 0; start_dest_index = '0; abort = 0; in_valid = 0; in_data = '0;
    endtask

    task automatic check_buffer(input string name);
        for (int k = 0; k < NELEM; k++)
            check(name, dest_coefficient[k], exp_vec[k]);
    endtask

    // Transaction-level model: the bench knows how many residues it handed over
    // (accepted = in_valid while in COLLECT); it expects elem_count to equal that,
    // and a single writeback of exp_vec right after the n-th one when n == NELEM.
    task automatic feed(input int n, input bit gaps, input int idx);
        int k = 0;
        int budget = 40 * NELEM;
        while (k < n && budget > 0) begin
            check("in_ready_collect", in_ready, 1);
            check("no_early_dest_valid", dest_valid, 0);
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? exp_vec[k] : 16'($urandom);
            start    = 1'($urandom_range(0, 1));
            start_dest_index = 4'(9);
            tick();
            if (in_valid) k++;
            check("elem_count_track", elem_count, k);
            check("idx_held", dest_register_index, idx);
            budget--;
        end
        in_valid = 0;
        start    = 0;
        if (budget == 0) check("feed_timeout", k, n);
        if (n == NELEM) begin
            check("flush_dest_valid", dest_valid, 1);
            check("flush_busy", busy, 1);
            check("flush_start_ready", start_ready, 1);
            check("flush_count", elem_count, NELEM);
            check("flush_index", dest_register_index, idx);
            check_buffer("flush_data");
            pulse_cyc = cyc;
        end
    endtask

    task automatic do_start(input int idx);
        start = 1; start_dest_index = 4'(idx);
        tick();
        start = 0;
        check("start_in_ready", in_ready, 1);
        check("start_count0", elem_count, 0);
        check("start_index", dest_register_index, idx);
    endtask

    task automatic end_flush_idle();
        tick();
        check("post_flush_dest_valid", dest_valid, 0);
        check("post_flush_busy", busy, 0);
        check("post_flush_start_ready", start_ready, 1);
        check("post_flush_data_stable", dest_coefficient[NELEM-1], exp_vec[NELEM-1]);
    endtask

    typedef struct {
        logic       rst, st, ab, iv;
        logic [3:0] idx;
        logic [15:0] dat;
        logic       e_sr, e_ir, e_dv, e_busy;
        int         e_cnt;
        int         e_idx;
    } vec_rec_t;

    initial begin
        vec_rec_t tbl[8];
        int p1;
        idle_inputs();

        // reset, ignored in_valid in IDLE, start, one element, ignored start, aborts
        tbl[0] = '{1, 0, 0, 1, 4'd6, 16'h00AA, 1, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 1, 4'd6, 16'h00AA, 1, 0, 0, 0, 0, 0};
        tbl[2] = '{0, 1, 0, 0, 4'd3, 16'h0000, 0, 1, 0, 1, 0, 3};
        tbl[3] = '{0, 0, 0, 1, 4'd0, 16'h0011, 0, 1, 0, 1, 1, 3};
        tbl[4] = '{0, 1, 0, 0, 4'd9, 16'h0000, 0, 1, 0, 1, 1, 3};
        tbl[5] = '{0, 0, 0, 1, 4'd9, 16'h0022, 0, 1, 0, 1, 2, 3};
        tbl[6] = '{0, 0, 1, 1, 4'd0, 16'h0033, 1, 0, 0, 0, 0, 3};
        tbl[7] = '{0, 1, 1, 0, 4'd8, 16'h0000, 0, 1, 0, 1, 0, 8};
        for (int i = 0; i < 8; i++) begin
            reset = tbl[i].rst; start = tbl[i].st; abort = tbl[i].ab;
            in_valid = tbl[i].iv; start_dest_index = tbl[i].idx; in_data = tbl[i].dat;
            tick();
            check($sformatf("tbl%0d_start_ready", i), start_ready, tbl[i].e_sr);
            check($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_ir);
            check($sformatf("tbl%0d_dest_valid", i), dest_valid, tbl[i].e_dv);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            check($sformatf("tbl%0d_count", i), elem_count, tbl[i].e_cnt);
            check($sformatf("tbl%0d_index", i), dest_register_index, tbl[i].e_idx);
        end
        check("abort_keeps_elem0", dest_coefficient[0], 16'h0011);
        check("abort_keeps_elem1", dest_coefficient[1], 16'h0022);
        check("abort_no_elem2", dest_coefficient[2], 0);

        // basic collection to index 5
        idle_inputs(); reset = 1; tick(); reset = 0;
        check("reset_coeff_zero", dest_coefficient, 0);
        for (int k = 0; k < NELEM; k++) exp_vec[k] = 16'(k + 1);
        do_start(5);
        feed(NELEM, 0, 5);
        end_flush_idle();

        // back-to-back: index 2 then 7, start in the FLUSH cycle
        for (int k = 0; k < NELEM; k++) exp_vec[k] = 16'(16'h0100 + k);
        do_start(2);
        feed(NELEM, 0, 2);
        p1 = pulse_cyc;
        for (int k = 0; k < NELEM; k++) exp_vec[k] = 16'(16'h0200 + 3 * k);
        do_start(7);
        check("b2b_flush_not_repeated", dest_valid, 0);
        feed(NELEM, 0, 7);
        check("b2b_period", pulse_cyc - p1, NELEM + 1);
        end_flush_idle();

        // abort after 3 elements
        do_start(1);
        feed(3, 0, 1);
        abort = 1; tick(); abort = 0;
        check("abort3_busy", busy, 0);
        check("abort3_count", elem_count, 0);
        check("abort3_dest_valid", dest_valid, 0);
        tick();
        check("abort3_still_no_dv", dest_valid, 0);

        // abort coincident with the last element
        do_start(4);
        feed(NELEM - 1, 0, 4);
        in_valid = 1; in_data = 16'hBEEF; abort = 1; tick(); in_valid = 0; abort = 0;
        check("abort_last_dest_valid", dest_valid, 0);
        check("abort_last_busy", busy, 0);
        check("abort_last_count", elem_count, 0);
        tick();
        check("abort_last_no_dv_later", dest_valid, 0);

        // reset mid-collection after half the elements
        do_start(11);
        feed(NELEM / 2, 0, 11);
        reset = 1; in_valid = 1; tick(); reset = 0; in_valid = 0;
        check("rst_mid_start_ready", start_ready, 1);
        check("rst_mid_in_ready", in_ready, 0);
        check("rst_mid_dest_valid", dest_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_count", elem_count, 0);
        check("rst_mid_index", dest_register_index, 0);
        check("rst_mid_coeff", dest_coefficient, 0);
        for (int k = 0; k < NELEM; k++) exp_vec[k] = 16'(16'h0F00 ^ k);
        do_start(12);
        feed(NELEM, 0, 12);
        end_flush_idle();

        // randomized collections with gaps
        for (int t = 0; t < 20; t++) begin
            int idx = $urandom_range(0, 15);
            for (int k = 0; k < NELEM; k++) exp_vec[k] = 16'($urandom);
            do_start(idx);
            feed(NELEM, 1, idx);
            end_flush_idle();
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1; tick(); in_valid = 0;
                check("rand_idle_ignored", busy, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
